alu_exec_unit: RTL
==================

// Module: alu_exec_unit
// PURPOSE
//  Multicycle execute unit: decodes ALUOp/funct3/funct7 into a 4-bit ALU control code and executes it on XLEN-bit operands.
//  Single-cycle ops finish in 1 cycle. Shifts run iteratively at 1 bit/cycle. Optional multiply runs shift-add.
//  Sits between the control FSM and the register file/ALUOut register; the control FSM holds its EX state until done.
// PARAMETERS
//  XLEN     32  operand/result width (>=8)
//  SHAMT_W  5   shift-amount width, = clog2(XLEN)
// PORTS
//  clk      in   1        clock, rising edge
//  reset    in   1        synchronous, active-high
//  start    in   1        launch op; sampled only when busy=0
//  alu_op   in   2        00 add, 01 sub, 10 R-type, 11 I-type
//  funct7   in   7        instruction [31:25]
//  funct3   in   3        instruction [14:12]
//  src_a    in   XLEN     operand A
//  src_b    in   XLEN     operand B / immediate
//  busy     out  1        operation in flight
//  done     out  1        1-cycle pulse; result valid
//  result   out  XLEN     registered result, held until next accepted start
//  zero     out  1        result==0, registered with result
//  illegal  out  1        undecodable op; registered with done
//  ctrl     out  4        latched control code of the current/last op
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, illegal, zero=0; result=0; ctrl=0000.
//  Decode on the accepted start, latched into ctrl. Operands are latched at the same time; later input changes are ignored.
//   alu_op 00 -> ADD 0010; 01 -> SUB 0110.
//   alu_op 10, funct7=0000000: f3 000 ADD, 001 SLL 0100, 010 SLT 1000, 011 SLTU 1001, 100 XOR 0011, 101 SRL 0101, 110 OR 0001, 111 AND 0000.
//   alu_op 10, funct7=0100000: f3 000 SUB, f3 101 SRA 0111; all other f3 are illegal.
//   alu_op 11: same f3 map, funct7 ignored except: f3 101 uses funct7[5] to pick SRA/SRL; f3 000 is always ADD.
//   Any other funct7 in R-type is illegal: ctrl=1111, result=0, illegal=1, done after 1 cycle.
//  FSM states: IDLE, EXEC, SHIFT, MUL.
//   IDLE + start -> EXEC (single-cycle op or illegal), SHIFT (SLL/SRL/SRA), or MUL. busy=1 from the next cycle.
//   EXEC: result is written. Next cycle busy=0 and done=1 -> IDLE. Start-to-done latency is 1 cycle.
//   SHIFT: cnt=src_b[SHAMT_W-1:0]. One bit shifted per cycle while cnt!=0 (SRA replicates the MSB). Exits when cnt==0.
//    Latency is shamt+1 cycles; shamt=0 gives 1 cycle with result=src_a.
//   MUL: product = low XLEN bits of src_a*src_b, 1 multiplier bit per cycle. Latency XLEN+1 cycles.
//  Arithmetic: ADD/SUB wrap mod 2^XLEN with no overflow flag. SLT is signed and SLTU is unsigned; result is 0 or 1, zero-extended.
//  Handshake: start while busy=1 is ignored; there is no queueing. start in the same cycle as done is accepted (back-to-back ops).
//  done is high exactly one cycle per accepted start. illegal is valid only with done.
//  result, zero and illegal hold until the next accepted start; they are not cleared at done.
//  Reset mid-operation aborts immediately: outputs return to reset values and no done is produced.
// CONFIGURATION
//  ALU_MUL_EN defined:
//   alu_op 10 with funct7=0000001 and f3=000 decodes to MUL 1010 (iterative, XLEN+1 cycles).
//   Other f3 values with funct7=0000001 are illegal.
//  ALU_MUL_EN undefined:
//   funct7=0000001 is illegal; the MUL state and multiplier logic are not synthesised.
// TESTING
//  1. reset=1 for 2 cycles mid-SLL with shamt=20 -> busy=0, done never pulses, result=0, ctrl=0000.
//  2. alu_op=10, f7=0100000, f3=000, a=5, b=7, start -> 1 cycle later done=1, result=32'hFFFFFFFE, ctrl=0110, zero=0.
//  3. alu_op=11, f3=101, f7[5]=1, a=32'h80000000, b=4 -> done exactly 5 cycles after start, result=32'hF8000000.
//     Same op with b=0 -> done after 1 cycle, result=32'h80000000.
//  4. alu_op=10, f7=0000001, f3=000, a=3, b=32'hFFFFFFFF:
//     with ALU_MUL_EN -> done after 33 cycles, result=32'hFFFFFFFD;
//     without -> done after 1 cycle, illegal=1, result=0.
//  5. Start SLL with shamt=31, re-pulse start with a new op while busy -> second start ignored, single done after 32 cycles.
//     Then assert start in the done cycle with alu_op=01, a=b=9 -> accepted, next done has zero=1.
//  6. Sweep all f3 values for R- and I-type with random a/b; compare result/ctrl against a reference model.
//     Also: SLT with a=-1, b=1 -> 1; SLTU with the same operands -> 0.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: multicycle execute unit (decode ALUOp/funct3/funct7, single-cycle ALU, iterative shifts, optional shift-add multiply)
// Ports: clk, reset (sync, active-high), start, alu_op[1:0], funct7[6:0], funct3[2:0], src_a/src_b[XLEN-1:0] in;
//        busy, done, result[XLEN-1:0], zero, illegal, ctrl[3:0] out.
// Build option: define ALU_MUL_EN to include the MUL state and multiplier datapath.
module alu_exec_unit #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      alu_op,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal,
  output logic [3:0]      ctrl
);
  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, MUL} state_t;
  localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010, C_XOR = 4'b0011;
  localparam logic [3:0] C_SLL = 4'b0100, C_SRL = 4'b0101, C_SUB = 4'b0110, C_SRA = 4'b0111;
  localparam logic [3:0] C_SLT = 4'b1000, C_SLTU = 4'b1001, C_ILL = 4'b1111;
`ifdef ALU_MUL_EN
  localparam logic [3:0] C_MUL = 4'b1010;
`endif
  state_t state, state_n;
  logic [3:0] base, dec;
  logic is_shift, is_mul;
  logic [XLEN-1:0] a_q, b_q, acc, alu, sh, res_n;
  logic [SHAMT_W:0] cnt;
  always_comb begin
    base = C_ADD;
    case (funct3)
      3'b001: base = C_SLL;
      3'b010: base = C_SLT;
      3'b011: base = C_SLTU;
      3'b100: base = C_XOR;
      3'b101: base = C_SRL;
      3'b110: base = C_OR;
      3'b111: base = C_AND;
      default: base = C_ADD;
    endcase
  end
  always_comb begin
    dec = C_ILL;
    if (alu_op == 2'b00) dec = C_ADD;
    else if (alu_op == 2'b01) dec = C_SUB;
    else if (alu_op == 2'b11) dec = (funct3 == 3'b101 && funct7[5]) ? C_SRA : base;
    else if (funct7 == 7'b0000000) dec = base;
    else if (funct7 == 7'b0100000) dec = funct3 == 3'b000 ? C_SUB : funct3 == 3'b101 ? C_SRA : C_ILL;
`ifdef ALU_MUL_EN
    else if (funct7 == 7'b0000001) dec = funct3 == 3'b000 ? C_MUL : C_ILL;
`endif
  end
  assign is_shift = dec == C_SLL || dec == C_SRL || dec == C_SRA;
`ifdef ALU_MUL_EN
  assign is_mul = dec == C_MUL;
`else
  assign is_mul = 1'b0;
`endif
  assign alu = ctrl == C_ADD  ? a_q + b_q :
               ctrl == C_SUB  ? a_q - b_q :
               ctrl == C_AND  ? a_q & b_q :
               ctrl == C_OR   ? a_q | b_q :
               ctrl == C_XOR  ? a_q ^ b_q :
               ctrl == C_SLT  ? {{(XLEN-1){1'b0}}, $signed(a_q) < $signed(b_q)} :
               ctrl == C_SLTU ? {{(XLEN-1){1'b0}}, a_q < b_q} : '0;
  assign sh = ctrl == C_SLL ? {acc[XLEN-2:0], 1'b0} : {ctrl == C_SRA & acc[XLEN-1], acc[XLEN-1:1]};
  assign res_n = state == EXEC ? alu : acc;
  assign busy = state != IDLE;
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = is_shift ? SHIFT : is_mul ? MUL : EXEC;
      EXEC: state_n = IDLE;
      default: if (cnt == '0) state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      done <= 1'b0;
      illegal <= 1'b0;
      zero <= 1'b0;
      result <= '0;
      ctrl <= '0;
      a_q <= '0;
      b_q <= '0;
      acc <= '0;
      cnt <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          ctrl <= dec;
          a_q <= src_a;
          b_q <= src_b;
          acc <= is_mul ? '0 : src_a;
          cnt <= is_mul ? (SHAMT_W+1)'(XLEN) : {1'b0, src_b[SHAMT_W-1:0]};
        end
      end else if (state == EXEC || cnt == '0) begin
        result <= res_n;
        zero <= res_n == '0;
        illegal <= state == EXEC && ctrl == C_ILL;
        done <= 1'b1;
      end else if (state == SHIFT) begin
        acc <= sh;
        cnt <= cnt - 1'b1;
      end
`ifdef ALU_MUL_EN
      else begin
        acc <= b_q[0] ? acc + a_q : acc;
        a_q <= a_q << 1;
        b_q <= b_q >> 1;
        cnt <= cnt - 1'b1;
      end
`endif
    end
  end
endmodule
